// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states and pin-enable patterns.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;

    localparam logic [3:0] OE_OFF    = 4'b0000;
    localparam logic [3:0] OE_SINGLE = 4'b0010;
    localparam logic [3:0] OE_QUAD   = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

    function automatic logic is_read_cmd(input logic [7:0] op);
        return (op == CMD_READ) || (op == CMD_FAST_READ) || (op == CMD_QUAD_READ);
    endfunction

endpackage

// File: rtl/spi_flash_sync.sv
// Brings the asynchronous SPI pins into the clk domain and turns SCLK/CS_n transitions
// into single-cycle registered pulses.
module spi_flash_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_cs_n,
    input  logic i_sclk,
    input  logic i_mosi,
    output logic o_cs_n,
    output logic o_cs_fall,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_mosi
);

    logic r_cs_meta, r_cs_sync, r_cs_prev;
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_mosi_meta, r_mosi_sync;
    logic r_cs_fall, r_rise, r_fall, r_mosi;

    // CS_n flops clear to 0 so a select already low at reset release never looks like a new falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_cs_fall   <= r_cs_prev & ~r_cs_sync;
            r_rise      <= r_sclk_sync & ~r_sclk_prev;
            r_fall      <= ~r_sclk_sync & r_sclk_prev;
            r_mosi      <= r_mosi_sync;
        end
    end

    assign o_cs_n      = r_cs_sync;
    assign o_cs_fall   = r_cs_fall;
    assign o_sclk_rise = r_rise;
    assign o_sclk_fall = r_fall;
    assign o_mosi      = r_mosi;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: decodes 0x03/0x0B/0x6B and streams bytes from an attached
// synchronous byte memory on io[1] (single) or io[3:0] (quad).
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DUMMY_CLKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic [3:0]        spi_in,
    output logic [3:0]        spi_out,
    output logic [3:0]        spi_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              active
);

    localparam logic [5:0] LAST_DUMMY = 6'(DUMMY_CLKS - 1);

    logic        w_cs_n, w_cs_fall, w_rise, w_fall, w_mosi;
    logic        w_unused;
    logic [7:0]  w_opcode;
    logic [23:0] w_addr;
    logic [5:0]  w_last_unit;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [6:0]  r_cmd_sh;
    logic [22:0] r_addr_sh;
    logic [7:0]  r_shift;
    logic        r_quad;
    logic        r_fast;
    logic        r_load;

    spi_flash_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_cs_n      (spi_cs_n),
        .i_sclk      (spi_sclk),
        .i_mosi      (spi_in[0]),
        .o_cs_n      (w_cs_n),
        .o_cs_fall   (w_cs_fall),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall),
        .o_mosi      (w_mosi)
    );

    assign w_unused    = ^spi_in[3:1];
    assign w_opcode    = {r_cmd_sh, w_mosi};
    assign w_addr      = {r_addr_sh, w_mosi};
    assign w_last_unit = r_quad ? 6'd1 : 6'd7;

    // Serial shifters carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_rise && r_state == CMD) begin
            r_cmd_sh <= w_opcode[6:0];
        end
        if (w_rise && r_state == ADDR) begin
            r_addr_sh <= w_addr[22:0];
        end
        if (r_load) begin
            r_shift <= mem_rdata;
        end else if (w_fall && r_state == DATA) begin
            r_shift <= r_quad ? {r_shift[3:0], 4'h0} : {r_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_quad   <= 1'b0;
            r_fast   <= 1'b0;
            r_load   <= 1'b0;
            spi_out  <= 4'h0;
            spi_oe   <= OE_OFF;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            active   <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            r_load <= mem_rd;
            // A deselect overrides any SCLK edge arriving in the same cycle.
            if (w_cs_n) begin
                r_state <= IDLE;
                r_cnt   <= 6'd0;
                spi_out <= 4'h0;
                spi_oe  <= OE_OFF;
                active  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= CMD;
                            r_cnt   <= 6'd0;
                        end
                    end
                    CMD: begin
                        if (w_rise) begin
                            if (r_cnt == 6'd7) begin
                                r_cnt   <= 6'd0;
                                r_quad  <= (w_opcode == CMD_QUAD_READ);
                                r_fast  <= (w_opcode == CMD_FAST_READ) || (w_opcode == CMD_QUAD_READ);
                                r_state <= is_read_cmd(w_opcode) ? ADDR : IGNORE;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_rise) begin
                            if (r_cnt == 6'd23) begin
                                r_cnt    <= 6'd0;
                                mem_addr <= w_addr[ADDR_W-1:0];
                                mem_rd   <= 1'b1;
                                if (r_fast && DUMMY_CLKS > 0) begin
                                    r_state <= DUMMY;
                                end else begin
                                    r_state <= DATA;
                                    active  <= 1'b1;
                                end
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (w_rise) begin
                            if (r_cnt == LAST_DUMMY) begin
                                r_cnt   <= 6'd0;
                                r_state <= DATA;
                                active  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    DATA: begin
                        // The fetch for the next byte launches as the last bit/nibble leaves.
                        if (w_fall) begin
                            spi_oe  <= r_quad ? OE_QUAD : OE_SINGLE;
                            spi_out <= r_quad ? r_shift[7:4] : {2'b00, r_shift[7], 1'b0};
                            if (r_cnt == w_last_unit) begin
                                r_cnt    <= 6'd0;
                                mem_addr <= mem_addr + ADDR_W'(1);
                                mem_rd   <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    IGNORE: begin
                        r_state <= IGNORE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a mode-0 SPI initiator pushes expected bytes,
// a monitor reassembles MISO/quad bytes on SCLK rising edges and checks them.
module tb_spi_flash_responder;

    logic        clk;
    logic        reset;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic [3:0]  spi_in;
    logic [3:0]  spi_out;
    logic [3:0]  spi_oe;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        active;

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_sh = 8'h00;
    logic       mon_stray = 1'b0;
    int         mon_n = 0;

    spi_flash_responder #(.ADDR_W(12), .DUMMY_CLKS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_in    (spi_in),
        .spi_out   (spi_out),
        .spi_oe    (spi_oe),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench memory: mem[n] = n[7:0] ^ 0xA5, one clock read latency.
    always @(posedge clk) begin
        if (mem_rd === 1'b1) mem_rdata <= mem_addr[7:0] ^ 8'hA5;
    end

    always @(posedge clk) begin
        if (mem_rd === 1'b1) rd_cnt++;
        if (spi_oe !== 4'b0000) oe_cnt++;
    end

    // Monitor: sample on SCLK rising edges while the responder drives.
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n === 1'b1) begin
            mon_n     = 0;
            mon_stray = 1'b0;
        end else if (spi_oe === 4'b1111) begin
            mon_sh = {mon_sh[3:0], spi_out};
            mon_n += 4;
        end else if (spi_oe === 4'b0010) begin
            mon_sh = {mon_sh[6:0], spi_out[1]};
            mon_stray = mon_stray | spi_out[0] | spi_out[2] | spi_out[3];
            mon_n += 1;
        end else if (spi_oe !== 4'b0000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL oe_pattern: got %b, want 0010 or 1111", spi_oe);
        end
        if (mon_n == 8) begin
            mon_n = 0;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %h, no byte expected", mon_sh);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({mon_stray, active, mon_sh} !== {1'b0, 1'b1, e}) begin
                    n_fail++;
                    $display("FAIL data_byte: got %h (stray=%b active=%b), want %h", mon_sh, mon_stray, active, e);
                end
            end
            mon_stray = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic clk_bit(input logic b, input logic chk_idle);
        spi_in[0] = b;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b1;
        if (chk_idle) check("dummy_oe", {28'h0, spi_oe}, 32'h0);
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int n_addr,
                        input int n_dummy, input int n_data);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) clk_bit(op[i], 1'b0);
        for (int i = n_addr - 1; i >= 0; i--) clk_bit(addr[i], 1'b0);
        for (int i = 0; i < n_dummy; i++) clk_bit(1'b0, 1'b1);
        for (int i = 0; i < n_data; i++) clk_bit(1'b0, 1'b0);
    endtask

    task automatic cs_release();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_out"},  {28'h0, spi_out}, 32'h0);
        check({tag, "_spi_oe"},   {28'h0, spi_oe},  32'h0);
        check({tag, "_mem_rd"},   {31'h0, mem_rd},  32'h0);
        check({tag, "_mem_addr"}, {20'h0, mem_addr}, 32'h0);
        check({tag, "_active"},   {31'h0, active},  32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, oe0;
        reset    = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_in   = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Read 0x03 @0x000010, three bytes
        exp_q.push_back(8'hB5); exp_q.push_back(8'hB4); exp_q.push_back(8'hB7);
        rd0 = rd_cnt;
        xfer(8'h03, 24'h000010, 24, 0, 24);
        cs_release();
        check("read_rd_pulses_3or4", {31'h0, (rd_cnt - rd0 >= 3) && (rd_cnt - rd0 <= 4)}, 32'h1);
        check("read_bytes_left", exp_q.size(), 0);

        // Fast read 0x0B @0x000100, 8 dummies, two bytes
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA4);
        xfer(8'h0B, 24'h000100, 24, 8, 16);
        cs_release();
        check("fast_bytes_left", exp_q.size(), 0);

        // Quad read 0x6B @0x000FFE, four bytes across the wrap
        exp_q.push_back(8'h5B); exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA4);
        xfer(8'h6B, 24'h000FFE, 24, 8, 8);
        cs_release();
        check("quad_bytes_left", exp_q.size(), 0);

        // Unsupported opcode 0x9F followed by 40 clocks
        rd0 = rd_cnt;
        oe0 = oe_cnt;
        xfer(8'h9F, 24'h0, 0, 0, 40);
        cs_release();
        check("ignore_rd_pulses", rd_cnt - rd0, 0);
        check("ignore_oe_cycles", oe_cnt - oe0, 0);
        exp_q.push_back(8'hE7);
        xfer(8'h03, 24'h000042, 24, 0, 8);
        cs_release();
        check("after_ignore_bytes_left", exp_q.size(), 0);

        // Abort after four bits of the second byte
        exp_q.push_back(8'h95);
        xfer(8'h03, 24'h000030, 24, 0, 12);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_oe_off", {28'h0, spi_oe}, 32'h0);
        repeat (8) @(negedge clk);
        check("abort_bytes_left", exp_q.size(), 0);
        exp_q.push_back(8'hA5);
        xfer(8'h03, 24'h000000, 24, 0, 8);
        cs_release();
        check("after_abort_bytes_left", exp_q.size(), 0);

        // Reset during the address phase
        xfer(8'h03, 24'h000001, 10, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd0 = rd_cnt;
        oe0 = oe_cnt;
        for (int i = 0; i < 30; i++) clk_bit(i[0], 1'b0);
        check("post_reset_rd_pulses", rd_cnt - rd0, 0);
        check("post_reset_oe_cycles", oe_cnt - oe0, 0);
        cs_release();
        exp_q.push_back(8'hA4);
        xfer(8'h03, 24'h000001, 24, 0, 8);
        cs_release();
        check("after_reset_bytes_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI flash responder: the memory-device end of the SPI link the VGA SPI ROM initiator drives.
- Used as an on-chip/FPGA stand-in for the external flash Pmod, and as a bench target for the VGA SPI ROM design.
- Decodes Read (0x03), Fast Read (0x0B) and Quad Output Fast Read (0x6B) in SPI mode 0.
- Fetches bytes from an attached synchronous byte memory and shifts them out on io[1], or on io[3:0] for quad.

Parameters:
- ADDR_W, 12, memory address width; the 24-bit SPI address is truncated to its ADDR_W LSBs.
- DUMMY_CLKS, 8, dummy SCLK cycles for 0x0B and 0x6B.

Ports:
- clk  in  1  system clock; must be at least 4x the SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- spi_cs_n  in  1  chip select from the initiator, active low, asynchronous to clk.
- spi_sclk  in  1  serial clock from the initiator, asynchronous to clk.
- spi_in  in  4  io[3:0] input side; only io[0] (MOSI) is used.
- spi_out  out  4  io[3:0] output values.
- spi_oe  out  4  per-pin output enable, 1 = drive.
- mem_rd  out  1  one-cycle read strobe to the byte memory.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rdata  in  8  memory data, valid exactly 1 clk after mem_rd.
- active  out  1  high while a recognised command is in its DATA phase.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-high.
  - Reset values: spi_out=0, spi_oe=0, mem_rd=0, mem_addr=0, active=0, state=IDLE.
- Input capture:
  - cs_n, sclk and io[0] pass through 2-flop synchronisers.
  - Rising and falling SCLK edges are detected on the synchronised sclk.
  - All protocol actions occur the cycle after edge detection.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- Transitions:
  - IDLE -> CMD when synchronised cs_n falls; bit counter cleared.
  - CMD: shift MOSI in MSB first on each rising edge. After 8 bits, 0x03/0x0B/0x6B -> ADDR; any other opcode -> IGNORE.
  - ADDR: shift 24 bits on rising edges. On the 24th bit:
    - load mem_addr from the address LSBs and pulse mem_rd;
    - 0x03 -> DATA; 0x0B/0x6B -> DUMMY.
  - DUMMY: count DUMMY_CLKS rising edges, then -> DATA. The memory fetch was already issued in ADDR.
  - DATA: load mem_rdata into the shift register 1 clk after mem_rd. active=1.
  - IGNORE: outputs idle until cs_n rises.
  - Any state -> IDLE on the cycle synchronised cs_n is high. Same cycle: spi_oe=0, active=0, mem_rd=0. A partial byte is discarded.
- Data output:
  - Drive order: first bit/nibble drives on the first falling edge after the transition into DATA; each following bit/nibble drives on its own falling edge.
  - Single modes: spi_oe=4'b0010; spi_out[1] = shift MSB first; spi_out[0,2,3]=0.
  - Quad mode: spi_oe=4'b1111; spi_out[3:0] = high nibble then low nibble, with io3 = bit7 and io0 = bit4 for the high nibble.
- Byte sequencing:
  - When the last bit/nibble of a byte is driven, mem_addr increments and mem_rd pulses.
  - The next byte is loaded before the next falling edge; the 4x clock ratio guarantees this.
- Wrap-around: mem_addr increments modulo 2^ADDR_W (0xFFF -> 0x000 at the default width).
- Reset mid-transaction: returns to IDLE immediately and ignores SCLK until the next cs_n falling edge. A transaction already in progress when reset releases is not decoded.
- Simultaneous events: a cs_n rise in the same cycle as an SCLK edge is resolved in favour of cs_n.

Decomposition:
- Shared package spi_flash_pkg:
  - opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_QUAD_READ=8'h6B;
  - state enum;
  - OE patterns OE_SINGLE=4'b0010, OE_QUAD=4'b1111.
- One sub-module, spi_flash_sync: 2-flop synchronisers for cs_n/sclk/mosi plus SCLK rise/fall pulse generation.

Test Plan:
Bench memory: mem[n] = n[7:0] ^ 8'hA5. SCLK = clk/8 unless stated.
- 0x03, address 0x000010, 3 bytes -> MISO bytes B5, B4, B7. spi_oe=0010 only during data. mem_rd pulses 3 times (a fourth may be prefetched).
- 0x0B, address 0x000100, 8 dummy clocks, 2 bytes -> A5, A4. spi_oe=0 during dummy. No data bit before dummy clock 8 completes.
- 0x6B, address 0x000FFE, 4 bytes at default ADDR_W -> bytes 5B, 5A, A5, A4 (address wraps 0xFFF -> 0x000), presented on io[3:0] as nibbles 5,B,5,A,A,5,A,4. spi_oe=1111.
- Opcode 0x9F, then 40 more SCLK cycles -> spi_oe stays 0 and mem_rd never pulses. A following 0x03 transaction returns correct data.
- cs_n raised after bit 3 of the second data byte -> spi_oe=0 within 3 clk. A new 0x03 to address 0x000000 returns A5 from bit 0.
- Reset asserted during the ADDR phase -> all outputs are 0 in the same cycle. After reset release and a new cs_n falling edge, 0x03 to address 0x000001 returns A4.
